data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//   Responder end of the core's data-memory port: accepts ce/we/addr/wdata
//   requests from the pipeline's MEM stage, services them from an internal
//   word-addressed RAM after a programmable number of wait states, and
//   returns read data with a one-cycle ready pulse.
//   Sits outside the core beside the instruction memory and replaces the
//   zero-latency data memory model, so that stall-on-memory logic can be
//   exercised.
// PARAMETERS
//   ADDR_W   10  word-address width; RAM depth = 2**ADDR_W words of 32 bits
//   LATENCY  2   wait states between acceptance and response, 0..15
// PORTS
//   clk      in   1   sole clock, rising edge
//   rst_n    in   1   reset
//   ce_i     in   1   request valid (core data_ce_o)
//   we_i     in   1   1 = write, 0 = read (core data_we_o)
//   addr_i   in   32  byte address (core data_addr_o)
//   wdata_i  in   32  store data (core data_o)
//   rdata_o  out  32  load data (to core data_i); valid while ready_o=1
//   ready_o  out  1   one-cycle response strobe
//   err_o    out  1   one-cycle error strobe, coincident with ready_o
//   busy_o   out  1   1 while a request is in flight (state != IDLE)
// BEHAVIOUR
//   - One clock; reset is asynchronous and active-low.
//   - Reset: state=IDLE; cnt=0; rdata_o=0, ready_o=0, err_o=0, busy_o=0.
//     RAM contents are not reset. Reset mid-request aborts the request;
//     a write not yet committed is never performed.
//   - FSM states: IDLE, WAIT, RESP.
//     IDLE: if ce_i=1 at edge t, latch we/addr/wdata.
//       If LATENCY=0, go to RESP; otherwise go to WAIT with cnt=LATENCY-1.
//     WAIT: if cnt=0, go to RESP; otherwise decrement cnt.
//     RESP: go to IDLE unconditionally.
//   - ce_i is ignored in WAIT and RESP. The requester holds or re-issues.
//     A new request is sampled no earlier than the edge after RESP.
//     Throughput is one request per LATENCY+2 cycles.
//   - Timing: a request sampled at edge t enters RESP at edge t+LATENCY.
//     ready_o is registered and equals (state==RESP), so it is high for
//     exactly one cycle.
//   - Commit: on the edge entering RESP,
//     write: RAM[widx] <= wdata; rdata_o is set to 0.
//     read:  rdata_o <= RAM[widx].
//     widx = addr[ADDR_W+1:2].
//   - rdata_o holds its value after ready_o falls, until the next response.
//   - Error: err_o=1 in the RESP cycle if addr[1:0]!=0 (misaligned), or if
//     addr[31:ADDR_W+2]!=0 (out of range). On error there is no RAM write,
//     rdata_o=0, and ready_o still pulses.
//   - Address wrap: none. Out-of-range addresses error and never alias.
//   - busy_o=1 in WAIT and RESP, registered from the state.
// TESTING
//   1. LATENCY=2: write 0xDEADBEEF at 0x10 sampled at edge t
//      -> ready_o=1 only in the cycle after edge t+2; err_o=0.
//   2. Read 0x10 after test 1 -> rdata_o=0xDEADBEEF with ready_o.
//      Then read 0x14 (unwritten, preloaded 0) -> rdata_o=0.
//   3. Misaligned write 0xAAAA5555 at 0x12 -> ready_o=1 and err_o=1.
//      A following read of 0x10 still returns 0xDEADBEEF.
//   4. Out of range: ADDR_W=10, read 0x1000 -> err_o=1, rdata_o=0.
//      Write 0x1000 does not corrupt word 0.
//   5. ce_i held high for 10 cycles -> exactly one request is accepted
//      every LATENCY+2 cycles. A request changed during WAIT uses the
//      latched value.
//   6. rst_n dropped in WAIT of a write to 0x20 (old 0x11111111)
//      -> outputs are 0 immediately. After release, a read of 0x20
//      returns 0x11111111.
//   7. LATENCY=0 build: read sampled at edge t -> ready_o in the cycle
//      after edge t; busy_o=1 for that single cycle.

Source files
------------

// File: rtl/data_mem_responder.sv
// Data-memory responder: word-addressed RAM that answers ce/we requests after
// LATENCY wait states with a one-cycle ready (and error) strobe.
module data_mem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        ready_o,
  output logic        err_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  localparam int          DEPTH    = 1 << ADDR_W;
  localparam logic [3:0]  CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  logic [31:0] mem [DEPTH];

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;

  logic              cur_we;
  logic [31:0]       cur_addr;
  logic [31:0]       cur_wdata;
  logic [ADDR_W-1:0] widx;
  logic              bad;
  logic              mem_we;

  // With LATENCY=0 the commit happens on the accepting edge, so the live
  // request inputs must feed the commit path while still in IDLE.
  always_comb begin
    cur_we    = (state_q == S_IDLE) ? we_i    : we_q;
    cur_addr  = (state_q == S_IDLE) ? addr_i  : addr_q;
    cur_wdata = (state_q == S_IDLE) ? wdata_i : wdata_q;
    widx      = cur_addr[ADDR_W+1:2];
    bad       = (cur_addr[1:0] != 2'b00) || ((cur_addr >> (ADDR_W + 2)) != '0);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    mem_we  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (ce_i) begin
          we_d    = we_i;
          addr_d  = addr_i;
          wdata_d = wdata_i;
          if (LATENCY == 0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_RESP;
        else             cnt_d   = cnt_q - 4'd1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_RESP) begin
      if (bad) begin
        rdata_d = '0;
      end else if (cur_we) begin
        rdata_d = '0;
        mem_we  = 1'b1;
      end else begin
        rdata_d = mem[widx];
      end
    end

    ready_d = (state_d == S_RESP);
    err_d   = (state_d == S_RESP) && bad;
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  // RAM is not reset; the rst_n gate keeps a request held during reset from writing.
  always_ff @(posedge clk) begin
    if (mem_we && rst_n) mem[widx] <= cur_wdata;
  end

  assign rdata_o = rdata_q;
  assign ready_o = ready_q;
  assign err_o   = err_q;
  assign busy_o  = busy_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a LATENCY=2 instance and a LATENCY=0 instance.
module tb_data_mem_responder;

  logic        clk;
  logic        rst_n;
  logic        ce0, ce1, we;
  logic [31:0] addr, wdata;
  logic [31:0] rdata0, rdata1;
  logic        ready0, ready1, err0, err1, busy0, busy1;

  int passed = 0;
  int total  = 0;

  data_mem_responder #(.ADDR_W(10), .LATENCY(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .ce_i(ce0), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .rdata_o(rdata0), .ready_o(ready0), .err_o(err0), .busy_o(busy0)
  );

  data_mem_responder #(.ADDR_W(10), .LATENCY(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .ce_i(ce1), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .rdata_o(rdata1), .ready_o(ready1), .err_o(err1), .busy_o(busy1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Issue one request to the selected instance and follow it to its response
  // plus one cycle; lat counts edges from the sampling edge to ready.
  task automatic do_req(input bit sel, input logic w, input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic e, output logic [31:0] rd, output logic bsy,
                        output logic rdy_after, output logic [31:0] rd_after, output logic bsy_after);
    @(negedge clk);
    we = w; addr = a; wdata = d;
    if (sel) ce1 = 1'b1; else ce0 = 1'b1;
    @(posedge clk); #1;
    ce0 = 1'b0; ce1 = 1'b0;
    lat = 0;
    while (!(sel ? ready1 : ready0) && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    e   = sel ? err1 : err0;
    rd  = sel ? rdata1 : rdata0;
    bsy = sel ? busy1 : busy0;
    @(posedge clk); #1;
    rdy_after = sel ? ready1 : ready0;
    rd_after  = sel ? rdata1 : rdata0;
    bsy_after = sel ? busy1 : busy0;
  endtask

  int          lat;
  logic        e, bsy, rdy_a, bsy_a;
  logic [31:0] rd, rd_a;

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (ready0 !== 1'b0) $display("FAIL rst_ready0: got %b want 0", ready0); else passed++;
    total++; if (err0 !== 1'b0) $display("FAIL rst_err0: got %b want 0", err0); else passed++;
    total++; if (busy0 !== 1'b0) $display("FAIL rst_busy0: got %b want 0", busy0); else passed++;
    total++; if (rdata0 !== 32'h0) $display("FAIL rst_rdata0: got %h want 0", rdata0); else passed++;
    total++; if (ready1 !== 1'b0 || busy1 !== 1'b0) $display("FAIL rst_dut1: got ready=%b busy=%b want 0/0", ready1, busy1); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_preload();
    do_req(0, 1'b1, 32'h14, 32'h0, lat, e, rd, bsy, rdy_a, rd_a, bsy_a);
    do_req(0, 1'b1, 32'h20, 32'h1111_1111, lat, e, rd, bsy, rdy_a, rd_a, bsy_a);
    do_req(0, 1'b1, 32'h0, 32'h5A5A_5A5A, lat, e, rd, bsy, rdy_a, rd_a, bsy_a);
    total++; if (e !== 1'b0 || lat != 2) $display("FAIL preload_w0: got err=%b lat=%0d want 0/2", e, lat); else passed++;
  endtask

  task automatic test_write_latency();
    do_req(0, 1'b1, 32'h10, 32'hDEAD_BEEF, lat, e, rd, bsy, rdy_a, rd_a, bsy_a);
    total++; if (lat != 2) $display("FAIL wr_latency: got %0d want 2", lat); else passed++;
    total++; if (e !== 1'b0) $display("FAIL wr_err: got %b want 0", e); else passed++;
    total++; if (rd !== 32'h0) $display("FAIL wr_rdata: got %h want 0", rd); else passed++;
    total++; if (rdy_a !== 1'b0) $display("FAIL wr_ready_pulse: got %b want 0", rdy_a); else passed++;
    total++; if (bsy !== 1'b1 || bsy_a !== 1'b0) $display("FAIL wr_busy: got %b/%b want 1/0", bsy, bsy_a); else passed++;
  endtask

  task automatic test_read();
    do_req(0, 1'b0, 32'h10, 32'h0, lat, e, rd, bsy, rdy_a, rd_a, bsy_a);
    total++; if (rd !== 32'hDEAD_BEEF) $display("FAIL rd_10: got %h want deadbeef", rd); else passed++;
    total++; if (lat != 2 || e !== 1'b0) $display("FAIL rd_10_lat: got lat=%0d err=%b want 2/0", lat, e); else passed++;
    total++; if (rd_a !== 32'hDEAD_BEEF) $display("FAIL rd_hold: got %h want deadbeef", rd_a); else passed++;
    do_req(0, 1'b0, 32'h14, 32'h0, lat, e, rd, bsy, rdy_a, rd_a, bsy_a);
    total++; if (rd !== 32'h0) $display("FAIL rd_14: got %h want 0", rd); else passed++;
  endtask

  task automatic test_misaligned();
    do_req(0, 1'b1, 32'h12, 32'hAAAA_5555, lat, e, rd, bsy, rdy_a, rd_a, bsy_a);
    total++; if (lat != 2) $display("FAIL mis_ready: got lat=%0d want 2", lat); else passed++;
    total++; if (e !== 1'b1) $display("FAIL mis_err: got %b want 1", e); else passed++;
    do_req(0, 1'b0, 32'h10, 32'h0, lat, e, rd, bsy, rdy_a, rd_a, bsy_a);
    total++; if (rd !== 32'hDEAD_BEEF || e !== 1'b0) $display("FAIL mis_intact: got %h err=%b want deadbeef/0", rd, e); else passed++;
  endtask

  task automatic test_out_of_range();
    do_req(0, 1'b0, 32'h1000, 32'h0, lat, e, rd, bsy, rdy_a, rd_a, bsy_a);
    total++; if (e !== 1'b1) $display("FAIL oor_rd_err: got %b want 1", e); else passed++;
    total++; if (rd !== 32'h0) $display("FAIL oor_rd_data: got %h want 0", rd); else passed++;
    do_req(0, 1'b1, 32'h1000, 32'h1234_5678, lat, e, rd, bsy, rdy_a, rd_a, bsy_a);
    total++; if (e !== 1'b1 || lat != 2) $display("FAIL oor_wr: got err=%b lat=%0d want 1/2", e, lat); else passed++;
    do_req(0, 1'b0, 32'h0, 32'h0, lat, e, rd, bsy, rdy_a, rd_a, bsy_a);
    total++; if (rd !== 32'h5A5A_5A5A) $display("FAIL oor_word0: got %h want 5a5a5a5a", rd); else passed++;
  endtask

  task automatic test_back_to_back();
    int          n_rdy;
    int          first_idx;
    int          last_idx;
    int          bad_gap;
    logic [31:0] data_at [3];
    n_rdy = 0; first_idx = -1; last_idx = -1; bad_gap = 0;
    @(negedge clk);
    we = 1'b0; addr = 32'h10; ce0 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (i == 0) addr = 32'h14;
      if (ready0) begin
        if (n_rdy < 3) data_at[n_rdy] = rdata0;
        if (first_idx < 0) first_idx = i;
        else if (i - last_idx != 4) bad_gap++;
        last_idx = i;
        n_rdy++;
      end
    end
    ce0 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (n_rdy != 3) $display("FAIL b2b_count: got %0d want 3", n_rdy); else passed++;
    total++; if (first_idx != 2 || bad_gap != 0) $display("FAIL b2b_spacing: got first=%0d badgaps=%0d want 2/0", first_idx, bad_gap); else passed++;
    total++; if (n_rdy < 2 || data_at[0] !== 32'hDEAD_BEEF || data_at[1] !== 32'h0)
      $display("FAIL b2b_latched: got %h/%h want deadbeef/0", data_at[0], data_at[1]); else passed++;
    total++; if (busy0 !== 1'b0) $display("FAIL b2b_idle: got busy=%b want 0", busy0); else passed++;
  endtask

  task automatic test_reset_midreq();
    do_req(0, 1'b0, 32'h10, 32'h0, lat, e, rd, bsy, rdy_a, rd_a, bsy_a);
    @(negedge clk);
    we = 1'b1; addr = 32'h20; wdata = 32'h2222_2222; ce0 = 1'b1;
    @(posedge clk); #1;
    ce0 = 1'b0;
    total++; if (busy0 !== 1'b1) $display("FAIL midrst_inflight: got busy=%b want 1", busy0); else passed++;
    rst_n = 1'b0;
    #1;
    total++; if (busy0 !== 1'b0 || ready0 !== 1'b0 || err0 !== 1'b0) $display("FAIL midrst_ctrl: got busy=%b ready=%b err=%b want 0", busy0, ready0, err0); else passed++;
    total++; if (rdata0 !== 32'h0) $display("FAIL midrst_rdata: got %h want 0", rdata0); else passed++;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_req(0, 1'b0, 32'h20, 32'h0, lat, e, rd, bsy, rdy_a, rd_a, bsy_a);
    total++; if (rd !== 32'h1111_1111) $display("FAIL midrst_nowrite: got %h want 11111111", rd); else passed++;
  endtask

  task automatic test_latency0();
    do_req(1, 1'b1, 32'h8, 32'hCAFE_F00D, lat, e, rd, bsy, rdy_a, rd_a, bsy_a);
    total++; if (lat != 0 || e !== 1'b0) $display("FAIL l0_wr: got lat=%0d err=%b want 0/0", lat, e); else passed++;
    do_req(1, 1'b0, 32'h8, 32'h0, lat, e, rd, bsy, rdy_a, rd_a, bsy_a);
    total++; if (lat != 0) $display("FAIL l0_rd_latency: got %0d want 0", lat); else passed++;
    total++; if (rd !== 32'hCAFE_F00D) $display("FAIL l0_rd_data: got %h want cafef00d", rd); else passed++;
    total++; if (bsy !== 1'b1 || bsy_a !== 1'b0 || rdy_a !== 1'b0) $display("FAIL l0_busy: got busy=%b/%b ready_after=%b want 1/0/0", bsy, bsy_a, rdy_a); else passed++;
    do_req(1, 1'b0, 32'h3, 32'h0, lat, e, rd, bsy, rdy_a, rd_a, bsy_a);
    total++; if (e !== 1'b1 || lat != 0 || rd !== 32'h0) $display("FAIL l0_mis: got err=%b lat=%0d rd=%h want 1/0/0", e, lat, rd); else passed++;
  endtask

  initial begin
    ce0 = 1'b0; ce1 = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    rst_n = 1'b0;
    test_reset();
    test_preload();
    test_write_latency();
    test_read();
    test_misaligned();
    test_out_of_range();
    test_back_to_back();
    test_reset_midreq();
    test_latency0();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
